// File: rtl/xc_packet_pkg.sv
// Shared definitions for the correlator packet receiver: ASCII codes, header layout, FSM states.
package xc_packet_pkg;

    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam logic [7:0] ASCII_LF = 8'h0A;

    // Header field placement within the 64-bit header word
    localparam int unsigned TICK_LSB       = 0;
    localparam int unsigned TICK_W         = 16;
    localparam int unsigned FLAGS_LSB      = 16;
    localparam int unsigned FLAGS_W        = 4;
    localparam int unsigned LAG_CROSS_LSB  = 20;
    localparam int unsigned LAG_CROSS_W    = 8;
    localparam int unsigned LAG_AUTO_LSB   = 28;
    localparam int unsigned LAG_AUTO_W     = 8;
    localparam int unsigned DELAY_LSB      = 36;
    localparam int unsigned DELAY_W        = 12;
    localparam int unsigned NUM_INPUTS_LSB = 48;
    localparam int unsigned NUM_INPUTS_W   = 8;
    localparam int unsigned RESOLUTION_LSB = 56;
    localparam int unsigned RESOLUTION_W   = 8;

    localparam int unsigned PKT_CNT_W      = 16;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DISCARD
    } rx_state_e;

    typedef struct packed {
        logic       is_hex;
        logic [3:0] nibble;
    } nib_dec_t;

endpackage

// File: rtl/xc_packet_rx_ascii_nibble_decoder.sv
// Combinational ASCII byte to hex nibble decoder; accepts 0-9, A-F and a-f.
module ascii_nibble_decoder
    import xc_packet_pkg::*;
(
    input  logic [7:0] data_i,
    output nib_dec_t   dec_c
);

    always_comb begin
        dec_c = '0;
        if (data_i >= 8'h30 && data_i <= 8'h39) begin
            dec_c.is_hex = 1'b1;
            dec_c.nibble = 4'(data_i - 8'h30);
        end else if (data_i >= 8'h41 && data_i <= 8'h46) begin
            dec_c.is_hex = 1'b1;
            dec_c.nibble = 4'(data_i - 8'h37);
        end else if (data_i >= 8'h61 && data_i <= 8'h66) begin
            dec_c.is_hex = 1'b1;
            dec_c.nibble = 4'(data_i - 8'h57);
        end
    end

endmodule

// File: rtl/xc_packet_rx.sv
// Reassembles an ASCII-hex correlator packet (header, payload, timestamp) from a received byte stream.
// Define XC_PACKET_RX_HEADER_CHECK_EN to compare num_inputs/resolution against expected values.
module xc_packet_rx
    import xc_packet_pkg::*;
#(
    parameter int unsigned PAYLOAD_SIZE   = 384,
    parameter int unsigned HEADER_SIZE    = 64,
    parameter int unsigned FOOTER_SIZE    = 64,
    parameter int unsigned TIMEOUT_CYCLES = 1000000
`ifdef XC_PACKET_RX_HEADER_CHECK_EN
    ,
    parameter int unsigned EXP_NUM_INPUTS = 8,
    parameter int unsigned EXP_RESOLUTION = 24
`endif
) (
    input  logic                      sysclk,
    input  logic                      reset,
    input  logic                      enable,
    input  logic [7:0]                rx_data,
    input  logic                      rx_valid,
    output logic                      pkt_valid,
    output logic [PAYLOAD_SIZE-1:0]   pkt_payload,
    output logic [FOOTER_SIZE-1:0]    pkt_timestamp,
    output logic [TICK_W-1:0]         pkt_tick,
    output logic [FLAGS_W-1:0]        pkt_flags,
    output logic [LAG_CROSS_W-1:0]    pkt_lag_cross,
    output logic [LAG_AUTO_W-1:0]     pkt_lag_auto,
    output logic [DELAY_W-1:0]        pkt_delay_size,
    output logic [NUM_INPUTS_W-1:0]   pkt_num_inputs,
    output logic [RESOLUTION_W-1:0]   pkt_resolution,
    output logic [PKT_CNT_W-1:0]      pkt_count,
    output logic                      err_char,
    output logic                      err_length,
    output logic                      err_timeout,
    output logic                      err_header,
    output logic                      busy
);

    localparam int unsigned PKT_W = HEADER_SIZE + PAYLOAD_SIZE + FOOTER_SIZE;
    localparam int unsigned NIB_N = PKT_W / 4;
    localparam int unsigned CNT_W = $clog2(NIB_N + 1);
    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    nib_dec_t dec_c;

    ascii_nibble_decoder u_dec (
        .data_i (rx_data),
        .dec_c  (dec_c)
    );

    rx_state_e                state_q, state_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic [PKT_W-1:0]         sr_q, sr_d;
    logic [TMO_W-1:0]         tmo_q, tmo_d;
    logic [HEADER_SIZE-1:0]   hdr_q, hdr_d;
    logic [PAYLOAD_SIZE-1:0]  payload_q, payload_d;
    logic [FOOTER_SIZE-1:0]   ts_q, ts_d;
    logic [PKT_CNT_W-1:0]     pkt_count_q, pkt_count_d;
    logic                     pkt_valid_q, pkt_valid_d;
    logic                     err_char_q, err_char_d;
    logic                     err_length_q, err_length_d;
    logic                     err_timeout_q, err_timeout_d;
    logic                     busy_q, busy_d;
    logic [HEADER_SIZE-1:0]   hdr_sr_c;

    assign hdr_sr_c = sr_q[PKT_W-1 -: HEADER_SIZE];

`ifdef XC_PACKET_RX_HEADER_CHECK_EN
    logic err_header_q, err_header_d;
`endif

    // Next-state, field capture and error pulses
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        sr_d          = sr_q;
        tmo_d         = tmo_q;
        hdr_d         = hdr_q;
        payload_d     = payload_q;
        ts_d          = ts_q;
        pkt_count_d   = pkt_count_q;
        pkt_valid_d   = 1'b0;
        err_char_d    = 1'b0;
        err_length_d  = 1'b0;
        err_timeout_d = 1'b0;
`ifdef XC_PACKET_RX_HEADER_CHECK_EN
        err_header_d  = 1'b0;
`endif
        if (!enable) begin
            state_d = IDLE;
        end else if (rx_valid) begin
            tmo_d = '0;
            unique case (state_q)
                IDLE: begin
                    if (dec_c.is_hex) begin
                        sr_d    = PKT_W'(dec_c.nibble);
                        cnt_d   = CNT_W'(1);
                        state_d = SHIFT;
                    end
                end
                SHIFT: begin
                    if (dec_c.is_hex) begin
                        if (cnt_q == CNT_W'(NIB_N)) begin
                            err_length_d = 1'b1;
                            state_d      = DISCARD;
                        end else begin
                            sr_d  = {sr_q[PKT_W-5:0], dec_c.nibble};
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end else if (rx_data == ASCII_CR) begin
                        if (cnt_q == CNT_W'(NIB_N)) begin
                            pkt_valid_d = 1'b1;
                            hdr_d       = hdr_sr_c;
                            payload_d   = sr_q[FOOTER_SIZE +: PAYLOAD_SIZE];
                            ts_d        = sr_q[FOOTER_SIZE-1:0];
                            pkt_count_d = pkt_count_q + PKT_CNT_W'(1);
`ifdef XC_PACKET_RX_HEADER_CHECK_EN
                            err_header_d =
                                (8'(hdr_sr_c[NUM_INPUTS_LSB +: NUM_INPUTS_W] + 8'd1) != 8'(EXP_NUM_INPUTS)) ||
                                (hdr_sr_c[RESOLUTION_LSB +: RESOLUTION_W] != 8'(EXP_RESOLUTION));
`endif
                        end else begin
                            err_length_d = 1'b1;
                        end
                        state_d = IDLE;
                    end else if (rx_data != ASCII_LF) begin
                        err_char_d = 1'b1;
                        state_d    = DISCARD;
                    end
                end
                DISCARD: begin
                    if (rx_data == ASCII_CR) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end else if (state_q != IDLE) begin
            // A byte arriving on the expiry cycle takes the branch above instead
            if (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
                err_timeout_d = 1'b1;
                state_d       = IDLE;
            end else begin
                tmo_d = tmo_q + TMO_W'(1);
            end
        end
        if (state_d == IDLE) begin
            cnt_d = '0;
            tmo_d = '0;
        end
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            sr_q          <= '0;
            tmo_q         <= '0;
            hdr_q         <= '0;
            payload_q     <= '0;
            ts_q          <= '0;
            pkt_count_q   <= '0;
            pkt_valid_q   <= 1'b0;
            err_char_q    <= 1'b0;
            err_length_q  <= 1'b0;
            err_timeout_q <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            sr_q          <= sr_d;
            tmo_q         <= tmo_d;
            hdr_q         <= hdr_d;
            payload_q     <= payload_d;
            ts_q          <= ts_d;
            pkt_count_q   <= pkt_count_d;
            pkt_valid_q   <= pkt_valid_d;
            err_char_q    <= err_char_d;
            err_length_q  <= err_length_d;
            err_timeout_q <= err_timeout_d;
            busy_q        <= busy_d;
        end
    end

`ifdef XC_PACKET_RX_HEADER_CHECK_EN
    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            err_header_q <= 1'b0;
        end else begin
            err_header_q <= err_header_d;
        end
    end
    assign err_header = err_header_q;
`else
    assign err_header = 1'b0;
`endif

    assign pkt_valid      = pkt_valid_q;
    assign pkt_payload    = payload_q;
    assign pkt_timestamp  = ts_q;
    assign pkt_tick       = hdr_q[TICK_LSB +: TICK_W];
    assign pkt_flags      = hdr_q[FLAGS_LSB +: FLAGS_W];
    assign pkt_lag_cross  = hdr_q[LAG_CROSS_LSB +: LAG_CROSS_W];
    assign pkt_lag_auto   = hdr_q[LAG_AUTO_LSB +: LAG_AUTO_W];
    assign pkt_delay_size = hdr_q[DELAY_LSB +: DELAY_W];
    assign pkt_num_inputs = hdr_q[NUM_INPUTS_LSB +: NUM_INPUTS_W];
    assign pkt_resolution = hdr_q[RESOLUTION_LSB +: RESOLUTION_W];
    assign pkt_count      = pkt_count_q;
    assign err_char       = err_char_q;
    assign err_length     = err_length_q;
    assign err_timeout    = err_timeout_q;
    assign busy           = busy_q;

endmodule
